// File: rtl/switch_pkg.sv
// Shared types, field positions and small helpers for the switch output arbiter.
package switch_pkg;

    localparam int        N_PORTS   = 3;
    localparam logic [1:0] DST_DROP = 2'd0;
    localparam int        DST_MSB   = 7;
    localparam int        DST_LSB   = 6;
    localparam int        PAYLOAD_W = 6;

    typedef logic [1:0] port_idx_t;

    function automatic port_idx_t inc_mod3(input port_idx_t p);
        case (p)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic port_idx_t dst_of(input logic [7:0] b);
        return b[DST_MSB:DST_LSB];
    endfunction

endpackage

// File: rtl/switch_output_arbiter_if.sv
// Ingress FIFO heads, pop strobes and output RAM write ports of the arbiter.
interface switch_output_arbiter_if #(parameter int AW = 4);

    logic          empty1, empty2, empty3;
    logic [7:0]    q1, q2, q3;
    logic          rdreq1, rdreq2, rdreq3;
    logic [2:0]    drain;
    logic [2:0]    ram_we;
    logic [AW-1:0] ram_addr1, ram_addr2, ram_addr3;
    logic [7:0]    ram_data1, ram_data2, ram_data3;
    logic [AW:0]   occ1, occ2, occ3;
    logic [7:0]    drop_count;

    modport master (
        output empty1, empty2, empty3, q1, q2, q3, drain,
        input  rdreq1, rdreq2, rdreq3, ram_we,
        input  ram_addr1, ram_addr2, ram_addr3,
        input  ram_data1, ram_data2, ram_data3,
        input  occ1, occ2, occ3, drop_count
    );

    modport slave (
        input  empty1, empty2, empty3, q1, q2, q3, drain,
        output rdreq1, rdreq2, rdreq3, ram_we,
        output ram_addr1, ram_addr2, ram_addr3,
        output ram_data1, ram_data2, ram_data3,
        output occ1, occ2, occ3, drop_count
    );

endinterface

// File: rtl/switch_output_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter3
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_req,
    output logic [2:0] o_grant
);

    port_idx_t r_ptr;
    port_idx_t w_i0, w_i1, w_i2, w_gidx;
    logic      w_any;

    assign w_i0 = r_ptr;
    assign w_i1 = inc_mod3(w_i0);
    assign w_i2 = inc_mod3(w_i1);

    // first requester found scanning from the pointer
    always_comb begin
        w_gidx  = r_ptr;
        w_any   = 1'b0;
        o_grant = 3'b000;
        if (i_req[w_i0]) begin
            w_gidx = w_i0;
            w_any  = 1'b1;
        end else if (i_req[w_i1]) begin
            w_gidx = w_i1;
            w_any  = 1'b1;
        end else if (i_req[w_i2]) begin
            w_gidx = w_i2;
            w_any  = 1'b1;
        end else begin
            w_any  = 1'b0;
        end
        if (w_any) begin
            o_grant[w_gidx] = 1'b1;
        end else begin
            o_grant = 3'b000;
        end
    end

    // pointer update
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= inc_mod3(w_gidx);
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/switch_output_arbiter.sv
// Routes ingress FIFO heads to three output buffer RAMs with per-port
// round-robin arbitration, credit-tracked occupancy and a registered write stage.
module switch_output_arbiter
    import switch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    switch_output_arbiter_if.slave   bus
);

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [7:0]         w_q       [N_PORTS];
    logic [N_PORTS-1:0] w_valid, w_drop, w_gnt_in, w_gnt_any, w_elig;
    logic [N_PORTS-1:0] w_req     [N_PORTS];
    logic [N_PORTS-1:0] w_req_g   [N_PORTS];
    logic [N_PORTS-1:0] w_gnt     [N_PORTS];
    logic [7:0]         w_wdata   [N_PORTS];
    logic [AW:0]        w_occ_nxt [N_PORTS];
    logic [8:0]         w_drop_sum;
    logic [7:0]         w_drop_nxt;

    logic [2:0]         r_we;
    logic [AW-1:0]      r_addr    [N_PORTS];
    logic [AW-1:0]      r_wptr    [N_PORTS];
    logic [7:0]         r_data    [N_PORTS];
    logic [AW:0]        r_occ     [N_PORTS];
    logic [7:0]         r_drop_cnt;

    assign w_q[0]  = bus.q1;
    assign w_q[1]  = bus.q2;
    assign w_q[2]  = bus.q3;
    assign w_valid = {~bus.empty3, ~bus.empty2, ~bus.empty1};

    // decode destinations, drops and per-port eligibility; w_req[j] is the request vector of port j+1
    always_comb begin
        w_drop = 3'b000;
        w_elig = 3'b000;
        for (int j = 0; j < N_PORTS; j++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[j][i] = w_valid[i] && (dst_of(w_q[i]) == port_idx_t'(j + 1));
            end
            w_elig[j]   = (r_occ[j] < OCC_FULL) || ((r_occ[j] == OCC_FULL) && bus.drain[j]);
            w_req_g[j]  = (reset && w_elig[j]) ? w_req[j] : 3'b000;
        end
        for (int i = 0; i < N_PORTS; i++) begin
            w_drop[i] = w_valid[i] && (dst_of(w_q[i]) == DST_DROP);
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
        rr_arbiter3 u_arb (
            .clk     (clk),
            .reset   (reset),
            .i_req   (w_req_g[g]),
            .o_grant (w_gnt[g])
        );
    end

    // merge grants, build write words and next occupancy/drop count
    always_comb begin
        w_gnt_in = 3'b000;
        for (int j = 0; j < N_PORTS; j++) begin
            w_gnt_in     = w_gnt_in | w_gnt[j];
            w_gnt_any[j] = |w_gnt[j];
            w_wdata[j]   = 8'h00;
            for (int i = 0; i < N_PORTS; i++) begin
                w_wdata[j] = w_wdata[j] |
                    ({8{w_gnt[j][i]}} & {port_idx_t'(i + 1), w_q[i][PAYLOAD_W-1:0]});
            end
            case ({w_gnt_any[j], bus.drain[j]})
                2'b10:   w_occ_nxt[j] = r_occ[j] + (AW+1)'(1);
                2'b01:   w_occ_nxt[j] = (r_occ[j] == '0) ? r_occ[j] : r_occ[j] - (AW+1)'(1);
                default: w_occ_nxt[j] = r_occ[j];
            endcase
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {8'h00, w_drop[0]} + {8'h00, w_drop[1]} + {8'h00, w_drop[2]};
        w_drop_nxt = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    assign bus.rdreq1 = reset & (w_gnt_in[0] | w_drop[0]);
    assign bus.rdreq2 = reset & (w_gnt_in[1] | w_drop[1]);
    assign bus.rdreq3 = reset & (w_gnt_in[2] | w_drop[2]);

    // registered write stage, occupancy counters and drop counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we       <= 3'b000;
            r_drop_cnt <= 8'h00;
            for (int j = 0; j < N_PORTS; j++) begin
                r_addr[j] <= '0;
                r_wptr[j] <= '0;
                r_data[j] <= 8'h00;
                r_occ[j]  <= '0;
            end
        end else begin
            r_we       <= w_gnt_any;
            r_drop_cnt <= w_drop_nxt;
            for (int j = 0; j < N_PORTS; j++) begin
                r_occ[j] <= w_occ_nxt[j];
                if (w_gnt_any[j]) begin
                    r_addr[j] <= r_wptr[j];
                    r_data[j] <= w_wdata[j];
                    r_wptr[j] <= r_wptr[j] + AW'(1);
                end else begin
                    r_addr[j] <= r_addr[j];
                    r_data[j] <= r_data[j];
                    r_wptr[j] <= r_wptr[j];
                end
            end
        end
    end

    assign bus.ram_we     = r_we;
    assign bus.ram_addr1  = r_addr[0];
    assign bus.ram_addr2  = r_addr[1];
    assign bus.ram_addr3  = r_addr[2];
    assign bus.ram_data1  = r_data[0];
    assign bus.ram_data2  = r_data[1];
    assign bus.ram_data3  = r_data[2];
    assign bus.occ1       = r_occ[0];
    assign bus.occ2       = r_occ[1];
    assign bus.occ3       = r_occ[2];
    assign bus.drop_count = r_drop_cnt;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Directed bench for switch_output_arbiter: reset, contention, credit stall, drops, parallel routing.
module tb_switch_output_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    switch_output_arbiter_if #(.AW(4)) bus ();

    switch_output_arbiter #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdq();
        return 32'({bus.rdreq3, bus.rdreq2, bus.rdreq1});
    endfunction

    initial begin
        reset      = 1'b0;
        bus.empty1 = 1'b1;
        bus.empty2 = 1'b1;
        bus.empty3 = 1'b1;
        bus.q1     = 8'h00;
        bus.q2     = 8'h00;
        bus.q3     = 8'h00;
        bus.drain  = 3'b000;

        // reset with a valid head present
        bus.q1 = 8'h41; bus.empty1 = 1'b0;
        #1 chk("rdreq_in_reset", rdq(), 32'h0);
        tick();
        chk("rdreq_in_reset2", rdq(), 32'h0);
        chk("we_reset", 32'(bus.ram_we), 32'h0);
        chk("addr1_reset", 32'(bus.ram_addr1), 32'h0);
        chk("data1_reset", 32'(bus.ram_data1), 32'h0);
        chk("occ1_reset", 32'(bus.occ1), 32'h0);
        chk("drop_reset", 32'(bus.drop_count), 32'h0);
        tick();
        chk("we_reset2", 32'(bus.ram_we), 32'h0);
        reset = 1'b1;
        #1 chk("rdreq_after_release", rdq(), 32'h1);
        tick();
        chk("t1_we", 32'(bus.ram_we), 32'h1);
        chk("t1_addr1", 32'(bus.ram_addr1), 32'h0);
        chk("t1_data1", 32'(bus.ram_data1), 32'h41);
        chk("t1_occ1", 32'(bus.occ1), 32'h1);
        bus.empty1 = 1'b1;

        // drain down to zero, then drain underflow
        bus.drain = 3'b001;
        tick();
        chk("t6_occ1_drain", 32'(bus.occ1), 32'h0);
        chk("t6_we_idle", 32'(bus.ram_we), 32'h0);
        tick();
        chk("t6_occ1_underflow", 32'(bus.occ1), 32'h0);
        bus.drain = 3'b000;
        bus.empty1 = 1'b0;
        repeat (5) tick();
        chk("t6_addr1_fill", 32'(bus.ram_addr1), 32'h5);
        chk("t6_occ1_fill", 32'(bus.occ1), 32'h5);
        bus.drain = 3'b001;
        tick();
        chk("t6_we_wr_drain", 32'(bus.ram_we), 32'h1);
        chk("t6_addr1_wr_drain", 32'(bus.ram_addr1), 32'h6);
        chk("t6_occ1_wr_drain", 32'(bus.occ1), 32'h5);
        bus.drain = 3'b000;
        bus.empty1 = 1'b1;

        // three-way contention on port 2
        bus.q1 = 8'h85; bus.q2 = 8'h85; bus.q3 = 8'h85;
        bus.empty1 = 1'b0; bus.empty2 = 1'b0; bus.empty3 = 1'b0;
        #1 chk("t2_rdreq_a", rdq(), 32'h1);
        tick();
        chk("t2_we_a", 32'(bus.ram_we), 32'h2);
        chk("t2_data2_a", 32'(bus.ram_data2), 32'h45);
        chk("t2_addr2_a", 32'(bus.ram_addr2), 32'h0);
        chk("t2_rdreq_b", rdq(), 32'h2);
        tick();
        chk("t2_data2_b", 32'(bus.ram_data2), 32'h85);
        chk("t2_addr2_b", 32'(bus.ram_addr2), 32'h1);
        chk("t2_rdreq_c", rdq(), 32'h4);
        tick();
        chk("t2_data2_c", 32'(bus.ram_data2), 32'hC5);
        chk("t2_addr2_c", 32'(bus.ram_addr2), 32'h2);
        chk("t2_occ2", 32'(bus.occ2), 32'h3);
        bus.empty1 = 1'b1; bus.empty2 = 1'b1; bus.empty3 = 1'b1;
        tick();
        chk("t2_we_idle", 32'(bus.ram_we), 32'h0);
        chk("t2_data2_hold", 32'(bus.ram_data2), 32'hC5);

        // parallel routing to all three ports
        bus.q1 = 8'h41; bus.q2 = 8'h85; bus.q3 = 8'hC7;
        bus.empty1 = 1'b0; bus.empty2 = 1'b0; bus.empty3 = 1'b0;
        #1 chk("t5_rdreq", rdq(), 32'h7);
        tick();
        chk("t5_we", 32'(bus.ram_we), 32'h7);
        chk("t5_data1", 32'(bus.ram_data1), 32'h41);
        chk("t5_data2", 32'(bus.ram_data2), 32'h85);
        chk("t5_data3", 32'(bus.ram_data3), 32'hC7);
        chk("t5_addr1", 32'(bus.ram_addr1), 32'h7);
        chk("t5_addr2", 32'(bus.ram_addr2), 32'h3);
        chk("t5_addr3", 32'(bus.ram_addr3), 32'h0);

        // drops: three in one cycle, then saturation
        bus.q1 = 8'h00; bus.q2 = 8'h00; bus.q3 = 8'h00;
        #1 chk("t4_rdreq_all_drop", rdq(), 32'h7);
        tick();
        chk("t4_drop3", 32'(bus.drop_count), 32'h3);
        chk("t4_we_drop3", 32'(bus.ram_we), 32'h0);
        bus.empty1 = 1'b1; bus.empty3 = 1'b1; bus.q2 = 8'h3F;
        for (int i = 0; i < 300; i++) begin
            #1 chk("t4_rdreq2", rdq(), 32'h2);
            tick();
            chk("t4_we", 32'(bus.ram_we), 32'h0);
            chk("t4_drop_count", 32'(bus.drop_count), (i + 4 > 255) ? 32'd255 : 32'(i + 4));
        end
        bus.empty2 = 1'b1;

        // reset mid-operation with a live request
        bus.q3 = 8'hC1; bus.empty3 = 1'b0;
        #1 chk("t3_rdreq_pre", rdq(), 32'h4);
        reset = 1'b0;
        #1 chk("t3_rdreq_reset", rdq(), 32'h0);
        tick();
        chk("t3_we_reset", 32'(bus.ram_we), 32'h0);
        chk("t3_occ3_reset", 32'(bus.occ3), 32'h0);
        chk("t3_drop_reset", 32'(bus.drop_count), 32'h0);
        chk("t3_occ1_reset", 32'(bus.occ1), 32'h0);
        reset = 1'b1;

        // fill port 3 to DEPTH, stall, credit return with wrap
        for (int i = 0; i < 16; i++) begin
            #1 chk("t3_rdreq_fill", rdq(), 32'h4);
            tick();
            chk("t3_we_fill", 32'(bus.ram_we), 32'h4);
            chk("t3_addr3_fill", 32'(bus.ram_addr3), 32'(i));
        end
        chk("t3_occ3_full", 32'(bus.occ3), 32'd16);
        #1 chk("t3_rdreq_stall", rdq(), 32'h0);
        bus.q1 = 8'h41; bus.empty1 = 1'b0;
        #1 chk("t3_rdreq_no_hol", rdq(), 32'h1);
        tick();
        chk("t3_we_no_hol", 32'(bus.ram_we), 32'h1);
        chk("t3_occ3_stalled", 32'(bus.occ3), 32'd16);
        chk("t3_occ1_no_hol", 32'(bus.occ1), 32'h1);
        bus.empty1 = 1'b1;
        bus.drain = 3'b100;
        #1 chk("t3_rdreq_credit", rdq(), 32'h4);
        tick();
        chk("t3_we_credit", 32'(bus.ram_we), 32'h4);
        chk("t3_addr3_wrap", 32'(bus.ram_addr3), 32'h0);
        chk("t3_data3", 32'(bus.ram_data3), 32'hC1);
        chk("t3_occ3_credit", 32'(bus.occ3), 32'd16);
        bus.drain = 3'b000;
        #1 chk("t3_rdreq_restall", rdq(), 32'h0);
        tick();
        chk("t3_we_restall", 32'(bus.ram_we), 32'h0);
        chk("t3_occ3_end", 32'(bus.occ3), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
